lcd_spi_serializer: RTL and testbench

Byte-level SPI transmitter for the ST7789 LCD, sitting directly downstream of `st7789_mgr` in place of a generic driver. It runs the panel hardware-reset sequence after system reset, accepts an AXI-Stream byte stream whose `TUSER` bit selects command or data, and shifts each byte out MSB-first in SPI mode 0. It drives `LCD_RST`, `LCD_DC`, `LCD_SDA`, `LCD_SCK` and `LCD_CS` from a single clock.

---
 rtl/lcd_spi_serializer.sv | 157 +++++++++++++++
 tb/tb_lcd_spi_serializer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_serializer.sv
`default_nettype none
// ============================================================================
// Module  : lcd_spi_serializer
// Brief   : ST7789 panel reset sequencer plus AXI-Stream byte to SPI mode-0
//           serializer (MSB first, TUSER drives DC, TLAST releases CS).
// Revision: 1.0 - initial release
// ============================================================================
module lcd_spi_serializer #(
  parameter int CLK_DIV         = 2,
  parameter int RST_HOLD_CYCLES = 1000,
  parameter int RST_WAIT_CYCLES = 12000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] S_AXIS_TDATA,
  input  logic       S_AXIS_TUSER,
  input  logic       S_AXIS_TVALID,
  input  logic       S_AXIS_TLAST,
  output logic       S_AXIS_TREADY,
  output logic       LCD_RST,
  output logic       LCD_CS,
  output logic       LCD_DC,
  output logic       LCD_SDA,
  output logic       LCD_SCK,
  output logic       BUSY
);

  localparam int c_HALF_W = $clog2(CLK_DIV + 1);
  localparam int c_HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int c_WAIT_W = $clog2(RST_WAIT_CYCLES + 1);

  localparam logic [c_HALF_W-1:0] c_HALF_LAST = c_HALF_W'(CLK_DIV - 1);
  localparam logic [c_HALF_W-1:0] c_HALF_ONE  = c_HALF_W'(1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(RST_WAIT_CYCLES - 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);

  localparam logic [2:0] c_ST_RST_HOLD = 3'd0;
  localparam logic [2:0] c_ST_RST_WAIT = 3'd1;
  localparam logic [2:0] c_ST_IDLE     = 3'd2;
  localparam logic [2:0] c_ST_SHIFT    = 3'd3;
  localparam logic [2:0] c_ST_CS_GAP   = 3'd4;

  logic [2:0]          r_state;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_HALF_W-1:0] r_half_cnt;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shreg;
  logic                r_last;
  logic                r_lcd_rst;
  logic                r_cs;
  logic                r_dc;
  logic                r_sda;
  logic                r_sck;

  logic [2:0]          w_next_idx;
  logic                w_half_done;

  assign w_next_idx  = r_bit_idx - 3'd1;
  assign w_half_done = (r_half_cnt == c_HALF_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= c_ST_RST_HOLD;
      r_hold_cnt <= '0;
      r_wait_cnt <= '0;
      r_half_cnt <= '0;
      r_bit_idx  <= 3'd7;
      r_shreg    <= '0;
      r_last     <= 1'b0;
      r_lcd_rst  <= 1'b0;
      r_cs       <= 1'b1;
      r_dc       <= 1'b0;
      r_sda      <= 1'b0;
      r_sck      <= 1'b0;
    end else begin
      case (r_state)
        c_ST_RST_HOLD: begin
          if (r_hold_cnt == c_HOLD_LAST) begin
            r_state    <= c_ST_RST_WAIT;
            r_lcd_rst  <= 1'b1;
            r_wait_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
          end
        end
        c_ST_RST_WAIT: begin
          if (r_wait_cnt == c_WAIT_LAST) begin
            r_state <= c_ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
          end
        end
        c_ST_IDLE: begin
          // CS/DC/SDA deliberately keep their last values between bytes
          if (S_AXIS_TVALID) begin
            r_state    <= c_ST_SHIFT;
            r_shreg    <= S_AXIS_TDATA;
            r_last     <= S_AXIS_TLAST;
            r_dc       <= S_AXIS_TUSER;
            r_sda      <= S_AXIS_TDATA[7];
            r_cs       <= 1'b0;
            r_sck      <= 1'b0;
            r_half_cnt <= '0;
            r_bit_idx  <= 3'd7;
          end
        end
        c_ST_SHIFT: begin
          if (w_half_done) begin
            r_half_cnt <= '0;
            if (!r_sck) begin
              r_sck <= 1'b1;
            end else if (r_bit_idx == 3'd0) begin
              r_sck <= 1'b0;
              if (r_last) begin
                r_state <= c_ST_CS_GAP;
                r_cs    <= 1'b1;
              end else begin
                r_state <= c_ST_IDLE;
              end
            end else begin
              // falling edge: present the next bit while SCK is low
              r_sck     <= 1'b0;
              r_bit_idx <= w_next_idx;
              r_sda     <= r_shreg[w_next_idx];
            end
          end else begin
            r_half_cnt <= r_half_cnt + c_HALF_ONE;
          end
        end
        c_ST_CS_GAP: begin
          if (w_half_done) begin
            r_state    <= c_ST_IDLE;
            r_half_cnt <= '0;
          end else begin
            r_half_cnt <= r_half_cnt + c_HALF_ONE;
          end
        end
        default: begin
          r_state <= c_ST_RST_HOLD;
        end
      endcase
    end
  end

  assign S_AXIS_TREADY = (r_state == c_ST_IDLE);
  assign BUSY          = (r_state != c_ST_IDLE);
  assign LCD_RST       = r_lcd_rst;
  assign LCD_CS        = r_cs;
  assign LCD_DC        = r_dc;
  assign LCD_SDA       = r_sda;
  assign LCD_SCK       = r_sck;

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_lcd_spi_serializer
// Brief   : Randomized self-checking bench; instance A runs CLK_DIV=2 and
//           instance B runs CLK_DIV=1, observed one at a time through a mux.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lcd_spi_serializer;

  localparam int HOLD  = 4;
  localparam int WAIT  = 6;
  localparam int DIV_A = 2;
  localparam int DIV_B = 1;

  typedef struct {
    logic [7:0] data;
    logic       dc;
    int         hs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic       sel = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tuser = 1'b0;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;

  logic tready_a, lcd_rst_a, cs_a, dc_a, sda_a, sck_a, busy_a;
  logic tready_b, lcd_rst_b, cs_b, dc_b, sda_b, sck_b, busy_b;
  logic tready, lcd_rst, cs, dc, sda, sck, busy, m_rst;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  int   exp_ready = 0;
  bit   prev_last = 1'b1;
  int   hs_count = 0;
  int   aborted = 0;
  int   bytes_done = 0;
  int   stab_err = 0;
  int   mon_nbits = 0;
  logic mon_sck = 1'b0, mon_sda = 1'b0, mon_dc = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_spi_serializer #(.CLK_DIV(DIV_A), .RST_HOLD_CYCLES(HOLD), .RST_WAIT_CYCLES(WAIT)) u_dut_a (
    .CLK(clk), .RESET(rst_a), .S_AXIS_TDATA(s_tdata), .S_AXIS_TUSER(s_tuser),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(tready_a),
    .LCD_RST(lcd_rst_a), .LCD_CS(cs_a), .LCD_DC(dc_a), .LCD_SDA(sda_a),
    .LCD_SCK(sck_a), .BUSY(busy_a)
  );

  lcd_spi_serializer #(.CLK_DIV(DIV_B), .RST_HOLD_CYCLES(HOLD), .RST_WAIT_CYCLES(WAIT)) u_dut_b (
    .CLK(clk), .RESET(rst_b), .S_AXIS_TDATA(s_tdata), .S_AXIS_TUSER(s_tuser),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(tready_b),
    .LCD_RST(lcd_rst_b), .LCD_CS(cs_b), .LCD_DC(dc_b), .LCD_SDA(sda_b),
    .LCD_SCK(sck_b), .BUSY(busy_b)
  );

  assign tready  = sel ? tready_b  : tready_a;
  assign lcd_rst = sel ? lcd_rst_b : lcd_rst_a;
  assign cs      = sel ? cs_b      : cs_a;
  assign dc      = sel ? dc_b      : dc_a;
  assign sda     = sel ? sda_b     : sda_a;
  assign sck     = sel ? sck_b     : sck_a;
  assign busy    = sel ? busy_b    : busy_a;
  assign m_rst   = sel ? rst_b     : rst_a;

  function automatic int div_cur();
    return sel ? DIV_B : DIV_A;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  // Time labels: cyc is the index of the last rising edge. A handshake on
  // edge h makes outputs sampled after edge e belong to cycle N+1+(e-h).
  always @(negedge clk) begin
    if (m_rst) begin
      mon_nbits = 0;
    end else begin
      if (sck === 1'b1 && mon_sck === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("rise_unexpected", 1, 0);
        end else begin
          check("rise_time", cyc, exp_q[0].hs + div_cur() * (2 * mon_nbits + 1));
          check("cs_at_rise", cs, 0);
          check("dc_at_rise", dc, exp_q[0].dc);
          check("sda_bit", sda, exp_q[0].data[7 - mon_nbits]);
          mon_nbits++;
          if (mon_nbits == 8) begin
            void'(exp_q.pop_front());
            bytes_done++;
            mon_nbits = 0;
          end
        end
      end
      if (sck === 1'b1 && mon_sck === 1'b1 && (sda !== mon_sda || dc !== mon_dc))
        stab_err++;
    end
    mon_sck = sck;
    mon_sda = sda;
    mon_dc  = dc;
  end

  task automatic drive_idle();
    s_tvalid = 1'b0;
    s_tdata  = 8'($urandom);
    s_tuser  = 1'($urandom_range(0, 1));
    s_tlast  = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input bit which);
    int r, k_rst, k_rdy, bad;
    aborted += exp_q.size();
    exp_q.delete();
    s_tvalid = 1'b0;
    if (which) rst_b = 1'b1; else rst_a = 1'b1;
    @(posedge clk); #1;
    r = cyc;
    check("rst_lcd_rst", lcd_rst, 0);
    check("rst_cs", cs, 1);
    check("rst_sck", sck, 0);
    check("rst_sda", sda, 0);
    check("rst_dc", dc, 0);
    check("rst_tready", tready, 0);
    check("rst_busy", busy, 1);
    if (which) rst_b = 1'b0; else rst_a = 1'b0;
    k_rst = -1; k_rdy = -1; bad = 0;
    for (int k = 1; k <= HOLD + WAIT + 8 && k_rdy < 0; k++) begin
      @(posedge clk); #1;
      if (lcd_rst === 1'b1 && k_rst < 0) k_rst = k;
      if (lcd_rst !== 1'b1 && k_rst >= 0) bad++;
      if (cs !== 1'b1 || sck !== 1'b0 || busy !== ~tready) bad++;
      if (tready === 1'b1) k_rdy = k;
    end
    check("rst_low_cycles", k_rst, HOLD);
    check("rst_first_ready", k_rdy, HOLD + WAIT);
    check("rst_seq_outputs", bad, 0);
    exp_ready = r + HOLD + WAIT;
    prev_last = 1'b1;
  endtask

  // hold=1 keeps TVALID high throughout; otherwise TVALID is randomly
  // dropped while the DUT is not ready, which must not matter.
  task automatic send(input logic [7:0] d, input bit u, input bit l, input int gap,
                      input bit hold, output int hs);
    int start, first_rdy, waited;
    bit done;
    hs = -1; done = 1'b0; waited = 0; first_rdy = -1;
    repeat (gap) drive_idle();
    start = cyc;
    while (!done && waited < 300) begin
      if (tready === 1'b1 && first_rdy < 0) begin
        first_rdy = cyc;
        check("idle_cs", cs, prev_last);
      end
      s_tdata  = d;
      s_tuser  = u;
      s_tlast  = l;
      s_tvalid = (hold || tready === 1'b1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (s_tvalid && tready === 1'b1) begin
        hs = cyc + 1;
        exp_q.push_back('{data: d, dc: u, hs: hs});
        hs_count++;
        done = 1'b1;
      end
      @(posedge clk); #1;
      waited++;
    end
    if (!done) check("handshake_timeout", 0, 1);
    if (start <= exp_ready) check("ready_time", first_rdy, exp_ready);
    if (done) begin
      exp_ready = hs + 16 * div_cur() + (l ? div_cur() : 0);
      prev_last = l;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) drive_idle();
    check("drain", exp_q.size(), 0);
    repeat (3) drive_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int h, h1, h2, h3, cs_rise, rdy, n;
    logic [7:0] d;
    bit l;
    repeat (3) begin @(posedge clk); #1; end

    // instance A, CLK_DIV=2
    do_reset(1'b0);

    send(8'h2A, 1'b0, 1'b1, 0, 1'b0, h);
    cs_rise = -1; rdy = -1;
    for (int i = 0; i < 60 && rdy < 0; i++) begin
      drive_idle();
      if (cs === 1'b1 && cs_rise < 0) cs_rise = cyc;
      if (tready === 1'b1) rdy = cyc;
    end
    check("cmd_cs_low_end", cs_rise, h + 32);
    check("cmd_ready_back", rdy, h + 34);

    send(8'h2C, 1'b0, 1'b0, 0, 1'b1, h1);
    send(8'hF8, 1'b1, 1'b0, 0, 1'b1, h2);
    send(8'h00, 1'b1, 1'b1, 0, 1'b1, h3);
    check("multi_spacing_1", h2 - h1, 33);
    check("multi_spacing_2", h3 - h2, 33);

    for (int i = 0; i < 3; i++) send(8'hA5, 1'b1, 1'b1, 0, 1'b1, h);

    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      l = (i == 23) || ($urandom_range(0, 3) == 0);
      send(d, 1'($urandom_range(0, 1)), l, $urandom_range(0, 3), 1'b0, h);
    end
    drain();

    send(8'h5A, 1'b1, 1'b0, 0, 1'b0, h);
    n = 0;
    while (mon_nbits < 3 && n < 100) begin drive_idle(); n++; end
    check("midbyte_reached", mon_nbits, 3);
    do_reset(1'b0);
    send(8'h3C, 1'b0, 1'b1, 1, 1'b0, h);
    drain();

    // instance B, CLK_DIV=1
    rst_a = 1'b1;
    sel   = 1'b1;
    do_reset(1'b1);
    send(8'hFF, 1'b1, 1'b0, 0, 1'b1, h1);
    send(8'h01, 1'b1, 1'b1, 0, 1'b1, h2);
    check("div1_spacing", h2 - h1, 17);
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      l = (i == 7) || ($urandom_range(0, 2) == 0);
      send(d, 1'($urandom_range(0, 1)), l, $urandom_range(0, 2), 1'b0, h);
    end
    drain();

    check("sda_dc_stable_while_sck_high", stab_err, 0);
    check("bytes_vs_handshakes", bytes_done, hs_count - aborted);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
